crc16_frame_checker: RTL and testbench
======================================

// Module: crc16_frame_checker
// PURPOSE
//  Receive-side counterpart of the serial CRC-16/CDMA2000 generator.
//  Takes a serial frame, MSB first: DATA_BITS payload bits, then the 16-bit CRC.
//  Recomputes the CRC over the payload, compares it with the received CRC and reports pass/fail.
//  Sits between the serial link deserialiser and the frame consumer.
// PARAMETERS
//  DATA_BITS  32        payload length in bits per frame (>=1)
//  POLY       16'hC867  CRC polynomial (CDMA2000)
//  INIT       16'hFFFF  CRC register value loaded at frame start
// PORTS
//  CLK          in   1          rising-edge clock
//  RESET_N      in   1          asynchronous active-low reset
//  START        in   1          1-cycle pulse: begin a new frame
//  BIT_VALID    in   1          BIT_IN is valid this cycle
//  BIT_IN       in   1          serial frame bit, MSB first
//  BUSY         out  1          frame reception in progress
//  DONE         out  1          1-cycle pulse: result valid
//  CRC_OK       out  1          last frame CRC matched (held)
//  CRC_ERR      out  1          last frame CRC mismatched (held)
//  FRAME_ABORT  out  1          1-cycle pulse: frame restarted by START while BUSY
//  RX_DATA      out  DATA_BITS  received payload, first bit at MSB
//  RX_CRC       out  16         received CRC field
//  CALC_CRC     out  16         CRC computed over the payload
// BEHAVIOUR
//  Reset (async, RESET_N=0):
//   - All outputs and internal registers are cleared to 0; state is IDLE.
//   - Release takes effect on the next CLK edge.
//  States: IDLE -> DATA -> CHECK -> REPORT -> IDLE. Bit counter width is $clog2(DATA_BITS+16).
//  IDLE:
//   - BIT_VALID/BIT_IN are ignored.
//   - START: crc<=INIT, cnt<=0, CRC_OK<=0, CRC_ERR<=0, BUSY<=1, go to DATA.
//  DATA: on each BIT_VALID cycle:
//   - fb = crc[15]^BIT_IN; crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 0).
//   - RX_DATA <= {RX_DATA[DATA_BITS-2:0],BIT_IN}; cnt++.
//   - After bit DATA_BITS-1: CALC_CRC<=crc_next, cnt<=0, go to CHECK.
//  CHECK: on each BIT_VALID cycle:
//   - RX_CRC <= {RX_CRC[14:0],BIT_IN}.
//   - After the 16th bit, go to REPORT.
//  Gaps:
//   - Cycles with BIT_VALID=0 in DATA or CHECK change nothing. Gaps are unlimited; there is no timeout.
//  REPORT (exactly one cycle):
//   - DONE=1.
//   - CRC_OK = (RX_CRC==CALC_CRC); CRC_ERR is its inverse.
//   - BUSY<=0; go to IDLE.
//  Latency: DONE is asserted on the cycle after the edge that samples the last CRC bit.
//  Result hold: CRC_OK, CRC_ERR, RX_DATA, RX_CRC and CALC_CRC hold until the next START or reset.
//  START while in DATA or CHECK:
//   - FRAME_ABORT pulses 1 cycle.
//   - Frame restarts as from IDLE; a BIT_VALID bit in the same cycle is dropped.
//  START during REPORT:
//   - DONE/result for the completed frame is still issued.
//   - The new frame then starts; no abort pulse.
//  CRC_OK and CRC_ERR are never both 1.
//  DONE and FRAME_ABORT are never both 1.
// TESTING
//  T1 DATA_BITS=72, payload "123456789" (72'h313233343536373839), then 16'h4C06:
//     -> DONE 1 cycle after last bit, CRC_OK=1, CALC_CRC=16'h4C06, RX_DATA matches payload.
//  T2 Same payload, CRC field 16'h4C07:
//     -> CRC_ERR=1, CRC_OK=0, RX_CRC=16'h4C07, CALC_CRC=16'h4C06.
//  T3 T1 with random 0-5 cycle BIT_VALID gaps:
//     -> identical result to T1; BUSY high throughout the frame.
//  T4 START reasserted after 40 payload bits, then a full T1 frame:
//     -> FRAME_ABORT pulse, then CRC_OK=1.
//  T5 RESET_N low mid-CHECK:
//     -> all outputs 0 immediately without a CLK edge; BIT_VALID pulses in IDLE are ignored
//        until START.
//  T6 DATA_BITS=32, payload 32'h00000000, CRC from golden model, back-to-back frames with START
//     in the REPORT cycle:
//     -> two DONE pulses, both CRC_OK=1.

Source files
------------

// File: rtl/crc16_frame_checker.sv
// Serial CRC-16/CDMA2000 frame checker: shifts in DATA_BITS payload bits and a 16-bit CRC (MSB first),
// recomputes the CRC over the payload and reports match/mismatch with a one-cycle DONE pulse.
module crc16_frame_checker #(
  parameter int          DATA_BITS = 32,
  parameter logic [15:0] POLY      = 16'hC867,
  parameter logic [15:0] INIT      = 16'hFFFF
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 BIT_VALID,
  input  logic                 BIT_IN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 CRC_OK,
  output logic                 CRC_ERR,
  output logic                 FRAME_ABORT,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic [15:0]          RX_CRC,
  output logic [15:0]          CALC_CRC
);

  localparam int CW = $clog2(DATA_BITS + 16);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(15);

  // Handshake: a bit is consumed on every rising edge where BIT_VALID=1 in DATA or CHECK;
  // there is no back-pressure, so the sender may insert any number of idle cycles.
  typedef enum logic [1:0] {IDLE, DATA, CHECK, REPORT} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [15:0]          crc_q, crc_d;
  logic [15:0]          rx_crc_q, rx_crc_d;
  logic [15:0]          calc_crc_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 busy_q, done_q, ok_q, err_q, abort_q;
  logic                 fb;

  always_comb begin
    fb        = crc_q[15] ^ BIT_IN;
    crc_d     = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    rx_data_d = DATA_BITS'({rx_data_q, BIT_IN});
    rx_crc_d  = {rx_crc_q[14:0], BIT_IN};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      crc_q      <= '0;
      rx_crc_q   <= '0;
      calc_crc_q <= '0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      // START wins in every state; a bit presented alongside it is dropped.
      if (START) begin
        abort_q <= (state_q == DATA) || (state_q == CHECK);
        crc_q   <= INIT;
        cnt_q   <= '0;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= DATA;
      end else begin
        case (state_q)
          DATA: begin
            if (BIT_VALID) begin
              crc_q     <= crc_d;
              rx_data_q <= rx_data_d;
              if (cnt_q == LAST_DATA) begin
                calc_crc_q <= crc_d;
                cnt_q      <= '0;
                state_q    <= CHECK;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          CHECK: begin
            if (BIT_VALID) begin
              rx_crc_q <= rx_crc_d;
              if (cnt_q == LAST_CRC) begin
                done_q  <= 1'b1;
                ok_q    <= (rx_crc_d == calc_crc_q);
                err_q   <= (rx_crc_d != calc_crc_q);
                state_q <= REPORT;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          REPORT: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign CRC_OK      = ok_q;
  assign CRC_ERR     = err_q;
  assign FRAME_ABORT = abort_q;
  assign RX_DATA     = rx_data_q;
  assign RX_CRC      = rx_crc_q;
  assign CALC_CRC    = calc_crc_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Bench for crc16_frame_checker: a 72-bit and a 32-bit instance share the serial bit lines,
// each with its own START; results are checked against a polynomial-division CRC model.
module tb_crc16_frame_checker;

  logic clk, rst_n, start72, start32, bit_valid, bit_in;
  logic busy72, done72, ok72, err72, abort72;
  logic busy32, done32, ok32, err32, abort32;
  logic [71:0] rx_data72;
  logic [31:0] rx_data32;
  logic [15:0] rx_crc72, calc72, rx_crc32, calc32;

  logic        sel32;
  logic        o_busy, o_done, o_ok, o_err, o_abort;
  logic [71:0] o_rx_data;
  logic [15:0] o_rx_crc, o_calc;

  int checks = 0;
  int failures = 0;
  int busy_bad;

  localparam logic [71:0] T1_PAYLOAD = 72'h313233343536373839;

  crc16_frame_checker #(.DATA_BITS(72)) dut72 (
    .CLK(clk), .RESET_N(rst_n), .START(start72), .BIT_VALID(bit_valid), .BIT_IN(bit_in),
    .BUSY(busy72), .DONE(done72), .CRC_OK(ok72), .CRC_ERR(err72), .FRAME_ABORT(abort72),
    .RX_DATA(rx_data72), .RX_CRC(rx_crc72), .CALC_CRC(calc72)
  );

  crc16_frame_checker #(.DATA_BITS(32)) dut32 (
    .CLK(clk), .RESET_N(rst_n), .START(start32), .BIT_VALID(bit_valid), .BIT_IN(bit_in),
    .BUSY(busy32), .DONE(done32), .CRC_OK(ok32), .CRC_ERR(err32), .FRAME_ABORT(abort32),
    .RX_DATA(rx_data32), .RX_CRC(rx_crc32), .CALC_CRC(calc32)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (sel32) begin
      o_busy = busy32; o_done = done32; o_ok = ok32; o_err = err32; o_abort = abort32;
      o_rx_data = {40'h0, rx_data32}; o_rx_crc = rx_crc32; o_calc = calc32;
    end else begin
      o_busy = busy72; o_done = done72; o_ok = ok72; o_err = err72; o_abort = abort72;
      o_rx_data = rx_data72; o_rx_crc = rx_crc72; o_calc = calc72;
    end
  end

  // reference: CRC = (INIT * x^n + M * x^16) mod P, by long division
  function automatic logic [15:0] model_crc(input logic [71:0] payload, input int nbits);
    logic [87:0] r;
    logic [87:0] p;
    r = ({16'h0, payload} << 16) ^ ({72'h0, 16'hFFFF} << nbits);
    for (int i = nbits + 15; i >= 16; i--) begin
      if (r[i]) begin
        p = {71'h0, 17'h1C867};
        r = r ^ (p << (i - 16));
      end
    end
    return r[15:0];
  endfunction

  // drivers
  task automatic pulse_start();
    if (sel32) start32 = 1'b1; else start72 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; start72 = 1'b0;
  endtask

  task automatic send_bits(input logic [71:0] val, input int nbits, input int max_gap);
    for (int i = nbits - 1; i >= 0; i--) begin
      int gap;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        if (o_busy !== 1'b1) busy_bad++;
        bit_valid = 1'b0; bit_in = $urandom_range(0, 1);
        @(posedge clk); #1;
      end
      if (o_busy !== 1'b1) busy_bad++;
      bit_valid = 1'b1; bit_in = val[i];
      @(posedge clk); #1;
      bit_valid = 1'b0;
    end
  endtask

  // Returns in the cycle right after the edge that samples the last CRC bit.
  task automatic send_frame(input logic [71:0] payload, input int nbits, input logic [15:0] crc,
                            input int max_gap);
    busy_bad = 0;
    pulse_start();
    send_bits(payload, nbits, max_gap);
    send_bits({56'h0, crc}, 16, max_gap);
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; start72 = 0; start32 = 0; bit_valid = 0; bit_in = 0; sel32 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy72, done72, ok72, err72, abort72, rx_data72, rx_crc72, calc72} !== '0) begin
      failures++; $display("FAIL reset72: got nonzero outputs busy=%b rx_data=%h calc=%h expected 0", busy72, rx_data72, calc72);
    end
    checks++;
    if ({busy32, done32, ok32, err32, abort32, rx_data32, rx_crc32, calc32} !== '0) begin
      failures++; $display("FAIL reset32: got nonzero outputs busy=%b rx_data=%h calc=%h expected 0", busy32, rx_data32, calc32);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    sel32 = 0;
    send_frame(T1_PAYLOAD, 72, 16'h4C06, 0);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL t1_done: got %b expected 1", o_done); end
    checks++; if (o_ok !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL t1_ok: got ok=%b err=%b expected ok=1 err=0", o_ok, o_err); end
    checks++; if (o_calc !== 16'h4C06) begin failures++; $display("FAIL t1_calc: got %h expected 4c06", o_calc); end
    checks++; if (o_rx_data !== T1_PAYLOAD) begin failures++; $display("FAIL t1_rx_data: got %h expected %h", o_rx_data, T1_PAYLOAD); end
    @(posedge clk); #1;
    checks++; if (o_done !== 1'b0 || o_abort !== 1'b0) begin failures++; $display("FAIL t1_done_pulse: got done=%b abort=%b expected 0 0", o_done, o_abort); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after: got %b expected 0", o_busy); end
    checks++; if (o_ok !== 1'b1 || o_rx_crc !== 16'h4C06) begin failures++; $display("FAIL t1_hold: got ok=%b rx_crc=%h expected 1 4c06", o_ok, o_rx_crc); end
  endtask

  task automatic test_bad_crc();
    sel32 = 0;
    send_frame(T1_PAYLOAD, 72, 16'h4C07, 0);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL t2_done: got %b expected 1", o_done); end
    checks++; if (o_ok !== 1'b0 || o_err !== 1'b1) begin failures++; $display("FAIL t2_err: got ok=%b err=%b expected ok=0 err=1", o_ok, o_err); end
    checks++; if (o_rx_crc !== 16'h4C07) begin failures++; $display("FAIL t2_rx_crc: got %h expected 4c07", o_rx_crc); end
    checks++; if (o_calc !== 16'h4C06) begin failures++; $display("FAIL t2_calc: got %h expected 4c06", o_calc); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_gaps();
    sel32 = 0;
    send_frame(T1_PAYLOAD, 72, 16'h4C06, 5);
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL t3_busy: got %0d low-busy cycles expected 0", busy_bad); end
    checks++; if (o_done !== 1'b1 || o_ok !== 1'b1) begin failures++; $display("FAIL t3_result: got done=%b ok=%b expected 1 1", o_done, o_ok); end
    checks++; if (o_calc !== 16'h4C06 || o_rx_data !== T1_PAYLOAD) begin failures++; $display("FAIL t3_data: got calc=%h rx_data=%h expected 4c06 %h", o_calc, o_rx_data, T1_PAYLOAD); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    sel32 = 0;
    busy_bad = 0;
    pulse_start();
    send_bits(T1_PAYLOAD >> 32, 40, 1);
    start72 = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk); #1;
    start72 = 1'b0; bit_valid = 1'b0;
    checks++; if (o_abort !== 1'b1 || o_done !== 1'b0) begin failures++; $display("FAIL t4_abort: got abort=%b done=%b expected 1 0", o_abort, o_done); end
    @(posedge clk); #1;
    checks++; if (o_abort !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL t4_abort_pulse: got abort=%b busy=%b expected 0 1", o_abort, o_busy); end
    send_bits(T1_PAYLOAD, 72, 0);
    send_bits({56'h0, 16'h4C06}, 16, 0);
    checks++; if (o_done !== 1'b1 || o_ok !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL t4_result: got done=%b ok=%b err=%b expected 1 1 0", o_done, o_ok, o_err); end
    checks++; if (o_rx_data !== T1_PAYLOAD || o_calc !== 16'h4C06) begin failures++; $display("FAIL t4_data: got rx_data=%h calc=%h expected %h 4c06", o_rx_data, o_calc, T1_PAYLOAD); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random_frames();
    int bad_cnt;
    sel32 = 0;
    for (int n = 0; n < 20; n++) begin
      logic [71:0] payload;
      logic [15:0] good, sent;
      logic        corrupt;
      payload = {$urandom_range(0, 255), $urandom, $urandom};
      good    = model_crc(payload, 72);
      corrupt = $urandom_range(0, 1);
      sent    = corrupt ? (good ^ (16'h1 << $urandom_range(0, 15))) : good;
      send_frame(payload, 72, sent, 3);
      checks++;
      if (o_done !== 1'b1 || o_ok !== !corrupt || o_err !== corrupt) begin
        failures++; $display("FAIL rand_result[%0d]: got done=%b ok=%b err=%b expected 1 %b %b", n, o_done, o_ok, o_err, !corrupt, corrupt);
      end
      checks++;
      if (o_calc !== good || o_rx_crc !== sent || o_rx_data !== payload) begin
        failures++; $display("FAIL rand_fields[%0d]: got calc=%h rx_crc=%h rx_data=%h expected %h %h %h", n, o_calc, o_rx_crc, o_rx_data, good, sent, payload);
      end
      bad_cnt = $urandom_range(1, 3);
      repeat (bad_cnt) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_check();
    int leak;
    sel32 = 0;
    pulse_start();
    send_bits(T1_PAYLOAD, 72, 0);
    send_bits({56'h0, 16'h4C06} >> 11, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy72, done72, ok72, err72, abort72, rx_data72, rx_crc72, calc72} !== '0) begin
      failures++; $display("FAIL t5_async_reset: got busy=%b rx_data=%h rx_crc=%h calc=%h expected all 0", busy72, rx_data72, rx_crc72, calc72);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    leak = 0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = $urandom_range(0, 1);
      @(posedge clk); #1;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rx_data !== '0) leak++;
    end
    bit_valid = 1'b0;
    checks++; if (leak != 0) begin failures++; $display("FAIL t5_idle_ignore: got %0d cycles with activity expected 0", leak); end
    send_frame(T1_PAYLOAD, 72, 16'h4C06, 0);
    checks++; if (o_done !== 1'b1 || o_ok !== 1'b1) begin failures++; $display("FAIL t5_recover: got done=%b ok=%b expected 1 1", o_done, o_ok); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_crc;
    int          dones;
    sel32 = 1;
    dones = 0;
    exp_crc = model_crc(72'h0, 32);
    send_frame(72'h0, 32, exp_crc, 0);
    if (o_done === 1'b1) dones++;
    checks++; if (o_ok !== 1'b1 || o_calc !== exp_crc) begin failures++; $display("FAIL t6_first: got ok=%b calc=%h expected 1 %h", o_ok, o_calc, exp_crc); end
    pulse_start();
    checks++; if (o_abort !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL t6_restart: got abort=%b done=%b busy=%b expected 0 0 1", o_abort, o_done, o_busy); end
    send_bits(72'h0, 32, 0);
    send_bits({56'h0, exp_crc}, 16, 0);
    if (o_done === 1'b1) dones++;
    checks++; if (dones != 2) begin failures++; $display("FAIL t6_dones: got %0d done pulses expected 2", dones); end
    checks++; if (o_ok !== 1'b1 || o_err !== 1'b0 || o_rx_crc !== exp_crc) begin failures++; $display("FAIL t6_second: got ok=%b err=%b rx_crc=%h expected 1 0 %h", o_ok, o_err, o_rx_crc, exp_crc); end
    checks++; if (busy72 !== 1'b0 || done72 !== 1'b0) begin failures++; $display("FAIL t6_other_idle: got busy72=%b done72=%b expected 0 0", busy72, done72); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_gaps();
    test_abort();
    test_random_frames();
    test_reset_mid_check();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
